wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order write-back stage result
//  and a long-latency unit (LLU: mul/div, late load return) that completes out of band.
//  LLU results are queued in a small FIFO. They drain into free WB slots (WB not writing, or

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_result_fifo.sv | 74 +++++++
 rtl/wb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package wb_arb_pkg;
  localparam int unsigned WB_DATA_W = 64;
  localparam int unsigned WB_ADDR_W = 5;

  typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_state_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of queued long-latency results; exposes per-entry valid/rd
// so the top can build the pending-destination bitmap.
module wb_result_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_push,
  input  logic [REG_ADDR_W-1:0]           i_push_rd,
  input  logic [DATA_WIDTH-1:0]           i_push_data,
  input  logic                            i_pop,
  output logic [REG_ADDR_W-1:0]           o_head_rd,
  output logic [DATA_WIDTH-1:0]           o_head_data,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [CNT_W-1:0]                o_count,
  output logic [DEPTH-1:0]                o_ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] o_ent_rd
);
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (i_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: valid_q gates every consumer.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      rd_q[wr_ptr_q]   <= i_push_rd;
      data_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_head_rd   = rd_q[rd_ptr_q];
  assign o_head_data = data_q[rd_ptr_q];
  assign o_full      = (count_q == CNT_W'(DEPTH));
  assign o_empty     = (count_q == '0);
  assign o_count     = count_q;
  assign o_ent_valid = valid_q;
  assign o_ent_rd    = rd_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order WB result and
// queued long-latency results, forcing a slot when the queue head starves.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = WB_DATA_W,
  parameter int unsigned REG_ADDR_W   = WB_ADDR_W,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned CNT_W       = $clog2(DEPTH) + 1,
  localparam int unsigned AGE_W       = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_WIDTH-1:0]    i_wb_result,
  input  logic [REG_ADDR_W-1:0]    i_wb_rd_addr,
  input  logic                     i_wb_reg_we,
  input  logic                     i_llu_valid,
  input  logic [DATA_WIDTH-1:0]    i_llu_data,
  input  logic [REG_ADDR_W-1:0]    i_llu_rd_addr,
  output logic                     o_llu_ready,
  output logic                     o_rf_we,
  output logic [REG_ADDR_W-1:0]    o_rf_addr,
  output logic [DATA_WIDTH-1:0]    o_rf_data,
  output logic                     o_stall_wb,
  output logic [2**REG_ADDR_W-1:0] o_pending_rd,
  output logic [CNT_W-1:0]         o_fifo_count
);
  arb_state_t                       state_q, state_d;
  logic [AGE_W-1:0]                 age_q, age_d;
  logic                             wb_req, push, pop, full, empty;
  logic [REG_ADDR_W-1:0]            head_rd;
  logic [DATA_WIDTH-1:0]            head_data;
  logic [CNT_W-1:0]                 count;
  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  logic [2**REG_ADDR_W-1:0]         pending;

  assign wb_req      = i_wb_reg_we && (i_wb_rd_addr != '0);
  assign o_llu_ready = !full && !i_rst;
  // Writes to x0 are acknowledged but never stored.
  assign push        = i_llu_valid && o_llu_ready && (i_llu_rd_addr != '0);

  wb_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_rd   (i_llu_rd_addr),
    .i_push_data (i_llu_data),
    .i_pop       (pop),
    .o_head_rd   (head_rd),
    .o_head_data (head_data),
    .o_full      (full),
    .o_empty     (empty),
    .o_count     (count),
    .o_ent_valid (ent_valid),
    .o_ent_rd    (ent_rd)
  );

  always_comb begin
    state_d    = state_q;
    age_d      = age_q;
    pop        = 1'b0;
    o_rf_we    = 1'b0;
    o_rf_addr  = '0;
    o_rf_data  = '0;
    o_stall_wb = 1'b0;
    case (state_q)
      ARB_NORMAL: begin
        if (wb_req) begin
          o_rf_we   = 1'b1;
          o_rf_addr = i_wb_rd_addr;
          o_rf_data = i_wb_result;
          if (!empty) begin
            if (age_q == AGE_W'(STARVE_LIMIT - 1)) state_d = ARB_FORCE;
            else                                   age_d   = age_q + AGE_W'(1);
          end
        end else if (!empty) begin
          o_rf_we   = 1'b1;
          o_rf_addr = head_rd;
          o_rf_data = head_data;
          pop       = 1'b1;
          age_d     = '0;
        end
      end
      ARB_FORCE: begin
        o_stall_wb = 1'b1;
        state_d    = ARB_NORMAL;
        age_d      = '0;
        if (!empty) begin
          o_rf_we   = 1'b1;
          o_rf_addr = head_rd;
          o_rf_data = head_data;
          pop       = 1'b1;
        end
      end
      default: state_d = ARB_NORMAL;
    endcase
    if (i_rst) begin
      o_rf_we    = 1'b0;
      o_stall_wb = 1'b0;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_NORMAL;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (ent_valid[i]) pending[ent_rd[i]] = 1'b1;
  end

  assign o_pending_rd = i_rst ? '0 : pending;
  assign o_fifo_count = i_rst ? '0 : count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven checks of the write-port arbiter plus starvation and reset-in-force sequences.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] wb_result, llu_data, rf_data;
  logic [4:0]  wb_rd, llu_rd, rf_addr;
  logic        wb_we, llu_valid, llu_ready, rf_we, stall;
  logic [31:0] pending;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_WIDTH   (64),
    .REG_ADDR_W   (5),
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wb_result   (wb_result),
    .i_wb_rd_addr  (wb_rd),
    .i_wb_reg_we   (wb_we),
    .i_llu_valid   (llu_valid),
    .i_llu_data    (llu_data),
    .i_llu_rd_addr (llu_rd),
    .o_llu_ready   (llu_ready),
    .o_rf_we       (rf_we),
    .o_rf_addr     (rf_addr),
    .o_rf_data     (rf_data),
    .o_stall_wb    (stall),
    .o_pending_rd  (pending),
    .o_fifo_count  (count)
  );

  typedef struct {
    bit          rst;
    bit          wbwe;
    logic [4:0]  wbrd;
    logic [63:0] wbd;
    bit          lv;
    logic [4:0]  lrd;
    logic [63:0] ld;
    bit          e_we;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    bit          e_stall;
    bit          e_ready;
    logic [2:0]  e_cnt;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(bit r, bit we, logic [4:0] rd, logic [63:0] d,
                               bit lv, logic [4:0] lrd, logic [63:0] ld,
                               bit ewe, logic [4:0] ea, logic [63:0] ed,
                               bit es, bit er, logic [2:0] ec, logic [31:0] ep);
    vec_t v;
    v.rst = r; v.wbwe = we; v.wbrd = rd; v.wbd = d;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
    v.e_stall = es; v.e_ready = er; v.e_cnt = ec; v.e_pend = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit we, input logic [4:0] rd, input logic [63:0] d,
                       input bit lv, input logic [4:0] lrd, input logic [63:0] ld);
    rst = r; wb_we = we; wb_rd = rd; wb_result = d;
    llu_valid = lv; llu_rd = lrd; llu_data = ld;
  endtask

  initial begin
    int stall_at;

    drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    repeat (2) @(posedge clk);

    // Each row: inputs held for one cycle, outputs expected in that cycle before the edge.
    vecs.push_back(mkv(1, 0, 0, 0,      0, 0, 0,      0, 0, 0,      0, 0, 0, 0));
    // WB only
    vecs.push_back(mkv(0, 1, 5, 'hA5,   0, 0, 0,      1, 5, 'hA5,   0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 5, 'hA5,   0, 0, 0,      1, 5, 'hA5,   0, 1, 0, 0));
    // single LLU result drains into an idle slot
    vecs.push_back(mkv(0, 0, 0, 0,      1, 7, 'h11,   0, 0, 0,      0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      1, 7, 'h11,   0, 1, 1, 32'h80));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,      0, 1, 0, 0));
    // fill while WB busy; 5th push refused
    vecs.push_back(mkv(0, 1, 5, 'hA5,   1, 1, 'h101,  1, 5, 'hA5,   0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 5, 'hA5,   1, 2, 'h102,  1, 5, 'hA5,   0, 1, 1, 32'h02));
    vecs.push_back(mkv(0, 1, 5, 'hA5,   1, 3, 'h103,  1, 5, 'hA5,   0, 1, 2, 32'h06));
    vecs.push_back(mkv(0, 1, 5, 'hA5,   1, 4, 'h104,  1, 5, 'hA5,   0, 1, 3, 32'h0E));
    vecs.push_back(mkv(0, 1, 5, 'hA5,   1, 6, 'h106,  1, 5, 'hA5,   0, 0, 4, 32'h1E));
    vecs.push_back(mkv(0, 0, 0, 0,      1, 6, 'h106,  1, 1, 'h101,  0, 0, 4, 32'h1E));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      1, 2, 'h102,  0, 1, 3, 32'h1C));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      1, 3, 'h103,  0, 1, 2, 32'h18));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      1, 4, 'h104,  0, 1, 1, 32'h10));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,      0, 1, 0, 0));
    // two entries to r3, plus an x0 push that must vanish
    vecs.push_back(mkv(0, 0, 0, 0,      1, 3, 'h31,   0, 0, 0,      0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 5, 'hA5,   1, 3, 'h32,   1, 5, 'hA5,   0, 1, 1, 32'h08));
    vecs.push_back(mkv(0, 1, 5, 'hA5,   1, 0, 'hDEAD, 1, 5, 'hA5,   0, 1, 2, 32'h08));
    vecs.push_back(mkv(0, 1, 5, 'hA5,   0, 0, 0,      1, 5, 'hA5,   0, 1, 2, 32'h08));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      1, 3, 'h31,   0, 1, 2, 32'h08));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      1, 3, 'h32,   0, 1, 1, 32'h08));
    vecs.push_back(mkv(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,      0, 1, 0, 0));
    // WB write to x0 is not a request
    vecs.push_back(mkv(0, 1, 0, 'hFF,   0, 0, 0,      0, 0, 0,      0, 1, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].wbwe, vecs[i].wbrd, vecs[i].wbd,
            vecs[i].lv, vecs[i].lrd, vecs[i].ld);
      #1;
      chk($sformatf("v%0d.rf_we", i), 64'(rf_we), 64'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d.rf_addr", i), 64'(rf_addr), 64'(vecs[i].e_addr));
        chk($sformatf("v%0d.rf_data", i), rf_data, vecs[i].e_data);
      end
      chk($sformatf("v%0d.stall", i), 64'(stall), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d.ready", i), 64'(llu_ready), 64'(vecs[i].e_ready));
      chk($sformatf("v%0d.count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d.pending", i), 64'(pending), 64'(vecs[i].e_pend));
    end

    // Starvation: one entry, WB busy; 8 denied cycles then one forced slot.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 9, 64'h99);
    #1 chk("starve.push_cnt", 64'(count), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(0, 1, 5, 64'hA5, 0, 0, 0);
      #1;
      chk($sformatf("starve.deny%0d.stall", i), 64'(stall), 64'd0);
      chk($sformatf("starve.deny%0d.addr", i), 64'(rf_addr), 64'd5);
    end
    @(negedge clk); #1;
    chk("starve.force.stall", 64'(stall), 64'd1);
    chk("starve.force.we", 64'(rf_we), 64'd1);
    chk("starve.force.addr", 64'(rf_addr), 64'd9);
    chk("starve.force.data", rf_data, 64'h99);
    @(negedge clk); #1;
    chk("starve.after.stall", 64'(stall), 64'd0);
    chk("starve.after.addr", 64'(rf_addr), 64'd5);
    chk("starve.after.data", rf_data, 64'hA5);
    chk("starve.after.count", 64'(count), 64'd0);

    // Reset asserted during a forced slot with three entries queued.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 1, 5, 64'hA5, 1, 5'(10 + i), 64'(16'hC0 + i));
    end
    stall_at = -1;
    for (int i = 3; i < 20 && stall_at < 0; i++) begin
      @(negedge clk);
      drive(0, 1, 5, 64'hA5, 0, 0, 0);
      #1;
      if (stall === 1'b1) stall_at = i;
    end
    chk("rstforce.stall_cycle", 64'(stall_at), 64'd9);
    chk("rstforce.count_before", 64'(count), 64'd3);
    chk("rstforce.pend_before", 64'(pending), 64'h1C00);
    rst = 1'b1;
    #1;
    chk("rstforce.same.we", 64'(rf_we), 64'd0);
    chk("rstforce.same.stall", 64'(stall), 64'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstforce.next.count", 64'(count), 64'd0);
    chk("rstforce.next.pending", 64'(pending), 64'd0);
    chk("rstforce.next.stall", 64'(stall), 64'd0);
    chk("rstforce.next.we", 64'(rf_we), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
